// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU writeback stage: 2-entry result buffer with per-entry N/Z/C/V and committed flags
// Optional forwarding outputs when ALU_WB_FWD_EN is defined.
module alu_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_result,
  input  logic               in_carry,
  input  logic               in_a_msb,
  input  logic               in_b_msb,
  input  logic [2:0]         in_op,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_wen,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_we,
  output logic [RADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0]  out_data,
`ifdef ALU_WB_FWD_EN
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]  fwd_data,
`endif
  output logic [3:0]         flags
);

  logic [1:0]         count;
  logic               wr_ptr, rd_ptr;
  logic               rdy_en;
  logic [DATA_W-1:0]  mem_data [2];
  logic [RADDR_W-1:0] mem_rd   [2];
  logic               mem_we   [2];
  logic [3:0]         mem_flg  [2];

  logic               push, pop;
  logic               res_msb;
  logic               flg_c, flg_v;
  logic [3:0]         new_flg;

  // rdy_en keeps in_ready low through reset and rises on the first edge after release
  assign in_ready  = rdy_en && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_we   = out_valid ? mem_we[rd_ptr]   : 1'b0;
  assign out_rd   = out_valid ? mem_rd[rd_ptr]   : '0;
  assign out_data = out_valid ? mem_data[rd_ptr] : '0;

  always_comb begin
    res_msb = in_result[DATA_W-1];
    flg_c   = 1'b0;
    flg_v   = 1'b0;
    case (in_op)
      3'b000: begin
        flg_c = in_carry;
        flg_v = (in_a_msb == in_b_msb) && (res_msb != in_a_msb);
      end
      3'b001: begin
        flg_c = in_carry;
        flg_v = (in_a_msb != in_b_msb) && (res_msb != in_a_msb);
      end
      default: begin
        flg_c = 1'b0;
        flg_v = 1'b0;
      end
    endcase
    new_flg = {res_msb, (in_result == '0), flg_c, flg_v};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      rdy_en <= 1'b0;
      flags  <= 4'b0000;
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_rd[i]   <= '0;
        mem_we[i]   <= 1'b0;
        mem_flg[i]  <= 4'b0000;
      end
    end else begin
      rdy_en <= 1'b1;
      if (push) begin
        mem_data[wr_ptr] <= in_result;
        mem_rd[wr_ptr]   <= in_rd;
        mem_we[wr_ptr]   <= in_wen && (in_rd != '0);
        mem_flg[wr_ptr]  <= new_flg;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        flags  <= mem_flg[rd_ptr];
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_WB_FWD_EN
  // Youngest entry sits just behind the write pointer
  assign fwd_valid = out_valid && mem_we[~wr_ptr];
  assign fwd_rd    = fwd_valid ? mem_rd[~wr_ptr]   : '0;
  assign fwd_data  = fwd_valid ? mem_data[~wr_ptr] : '0;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb/tb_alu_wb_stage.sv - directed self-checking bench for alu_wb_stage
module tb_alu_wb_stage;
  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_ready;
  logic [DATA_W-1:0]  in_result;
  logic               in_carry, in_a_msb, in_b_msb;
  logic [2:0]         in_op;
  logic [RADDR_W-1:0] in_rd;
  logic               in_wen;
  logic               out_valid, out_ready, out_we;
  logic [RADDR_W-1:0] out_rd;
  logic [DATA_W-1:0]  out_data;
  logic [3:0]         flags;
`ifdef ALU_WB_FWD_EN
  logic               fwd_valid;
  logic [RADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0]  fwd_data;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  alu_wb_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_carry(in_carry), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
    .in_op(in_op), .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we),
    .out_rd(out_rd), .out_data(out_data),
`ifdef ALU_WB_FWD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] res,
                       input logic c, input logic am, input logic bm,
                       input logic [4:0] rd, input logic wen);
    in_valid = v; in_op = op; in_result = res; in_carry = c;
    in_a_msb = am; in_b_msb = bm; in_rd = rd; in_wen = wen;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // add, zero result, carry, signed overflow -> flags 0111
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 32'h0, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1);
    step();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_we", {31'd0, out_we}, 32'd1);
    chk("t1_out_rd", {27'd0, out_rd}, 32'd3);
    chk("t1_out_data", out_data, 32'd0);
    chk("t1_flags_prepop", {28'd0, flags}, 32'd0);
    step();
    chk("t1_flags", {28'd0, flags}, 32'h7);
    chk("t1_empty", {31'd0, out_valid}, 32'd0);

    // backpressure: 3 back-to-back, third held
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h10, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
    step();
    drive(1'b1, 3'b000, 32'h20, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
    step();
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 3'b000, 32'h30, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1);
    step();
    chk("bp_held", {31'd0, in_ready}, 32'd0);
    chk("bp_head1", out_data, 32'h10);
    out_ready = 1'b1;
    step();
    chk("bp_head2", out_data, 32'h20);
    chk("bp_rd2", {27'd0, out_rd}, 32'd2);
    chk("bp_ready_again", {31'd0, in_ready}, 32'd1);
    step();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("bp_head3", out_data, 32'h30);
    chk("bp_rd3", {27'd0, out_rd}, 32'd3);
    step();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    chk("bp_flags", {28'd0, flags}, 32'h2);

    // streaming at count 1: sub with C=1, V=1, N=1 -> 1011
    drive(1'b1, 3'b001, 32'h8000_0100, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
    step();
    for (int i = 1; i <= 4; i++) begin
      in_result = 32'h8000_0100 + i;
      step();
      chk("st_in_ready", {31'd0, in_ready}, 32'd1);
      chk("st_out_valid", {31'd0, out_valid}, 32'd1);
      chk("st_head", out_data, 32'h8000_0100 + i);
      chk("st_flags", {28'd0, flags}, 32'hB);
    end
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    chk("st_drained", {31'd0, out_valid}, 32'd0);

    // logic op, rd=0: not written, C/V cleared
    drive(1'b1, 3'b100, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1);
    step();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("rd0_out_valid", {31'd0, out_valid}, 32'd1);
    chk("rd0_out_we", {31'd0, out_we}, 32'd0);
    step();
    chk("rd0_flags", {28'd0, flags}, 32'h8);

    // async reset with buffer full
    out_ready = 1'b0;
    drive(1'b1, 3'b010, 32'hAA, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1);
    step();
    in_result = 32'hBB;
    step();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("ar_full", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_out_data", out_data, 32'd0);
    chk("ar_out_rd", {27'd0, out_rd}, 32'd0);
    chk("ar_flags", {28'd0, flags}, 32'd0);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_rel_ready", {31'd0, in_ready}, 32'd1);
    chk("ar_rel_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 3'b010, 32'hF000_0000, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
    step();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("ar_post_data", out_data, 32'hF000_0000);
    chk("ar_post_rd", {27'd0, out_rd}, 32'd4);
    step();
    chk("ar_post_flags", {28'd0, flags}, 32'h8);

`ifdef ALU_WB_FWD_EN
    out_ready = 1'b0;
    chk("fwd_idle", {31'd0, fwd_valid}, 32'd0);
    drive(1'b1, 3'b000, 32'h1234, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1);
    step();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("fwd_valid", {31'd0, fwd_valid}, 32'd1);
    chk("fwd_rd", {27'd0, fwd_rd}, 32'd7);
    chk("fwd_data", fwd_data, 32'h1234);
    out_ready = 1'b1;
    step();
    chk("fwd_cleared", {31'd0, fwd_valid}, 32'd0);
    chk("fwd_data_zero", fwd_data, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
